// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory burst reader
package mem_pkg;

    localparam int MEMORY_BUS_WIDTH_DEFAULT = 32;
    localparam logic [3:0] WB_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock fifo with show-ahead read port
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push while full is only taken when the same cycle frees a slot.
    assign do_push  = push && ((count != FULL_COUNT) || do_pop);
    // Storage is not reset, so the head is masked to zero whenever nothing is buffered.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - issues sequential word reads and streams them out with backpressure
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int MEMORY_BUS_WIDTH = MEMORY_BUS_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH       = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [31:0]                 cmd_addr,
    input  logic [15:0]                 cmd_len,
    output logic [ADDR_WIDTH-1:0]       mem_addr_out,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out,
    output logic [3:0]                  mem_wb_out,
    input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MEMORY_BUS_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    reader_state_t         state;
    logic [15:0]           remaining;
    logic [1:0]            inflight;
    logic                  issued_q;
    logic                  issued_last_q;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [MEMORY_BUS_WIDTH:0] fifo_head;
    logic [OW-1:0]         occupancy;
    logic                  issue;
    logic                  pop;
    logic                  last_beat;
    logic                  unused_addr_bits;

    assign mem_data_out     = '0;
    assign mem_wb_out       = WB_NONE;
    assign unused_addr_bits = ^cmd_addr;

    // Reads already issued but not yet written reserve their fifo slot up front.
    assign occupancy = OW'(fifo_count) + OW'(inflight);
    assign issue     = (state == ST_READ) && (remaining != 16'd0) && (occupancy < OW'(FIFO_DEPTH));

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[MEMORY_BUS_WIDTH-1:0];
    assign out_last  = fifo_head[MEMORY_BUS_WIDTH];
    assign pop       = out_valid && out_ready;
    assign last_beat = pop && out_last;

    sync_fifo #(
        .WIDTH (MEMORY_BUS_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (issued_q),
        .push_data ({issued_last_q, mem_data_in}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_addr_out  <= '0;
            remaining     <= 16'd0;
            inflight      <= 2'd0;
            issued_q      <= 1'b0;
            issued_last_q <= 1'b0;
        end else begin
            done          <= 1'b0;
            issued_q      <= issue;
            issued_last_q <= issue && (remaining == 16'd1);

            case ({issue, issued_q})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            mem_addr_out <= cmd_addr[ADDR_WIDTH+1:2];
                            remaining    <= cmd_len;
                            state        <= ST_READ;
                            cmd_ready    <= 1'b0;
                            busy         <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    // mem_addr_out is the address presented this cycle; it wraps naturally.
                    if (issue) begin
                        mem_addr_out <= mem_addr_out + 1'b1;
                        remaining    <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_beat) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// tb/tb_mem_burst_reader.sv - scoreboard bench for mem_burst_reader
module tb_mem_burst_reader;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [15:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_wb_out;
    logic [31:0] mem_data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [32:0] sb[$];

    mem_burst_reader #(
        .MEMORY_BUS_WIDTH (32),
        .ADDR_WIDTH       (16),
        .FIFO_DEPTH       (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_wb_out   (mem_wb_out),
        .mem_data_in  (mem_data_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: registered read, word content tags its own address.
    always @(posedge clock) mem_data_in <= 32'hA500_0000 | {16'h0000, mem_addr_out};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [15:0] len);
        logic [15:0] w;
        @(negedge clock);
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        w = addr[17:2];
        for (int i = 0; i < int'(len); i++) begin
            sb.push_back({(i == int'(len) - 1), 32'hA500_0000 | {16'h0000, w}});
            w = w + 16'd1;
        end
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check(name, seen, 1);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin
        logic        stalled;
        logic [32:0] held;
        logic [32:0] exp;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid_held", out_valid, 1);
                    check("stall_word_held", {out_last, out_data}, held);
                end
                if (out_valid && out_ready) begin
                    pops++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word actual=%0h required=none", {out_last, out_data});
                    end else begin
                        exp = sb.pop_front();
                        check("stream_word", {out_last, out_data}, exp);
                    end
                end
                stalled = out_valid && !out_ready;
                held    = {out_last, out_data};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_v;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mem_addr", mem_addr_out, 0);
        check("rst_mem_data_out", mem_data_out, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic burst: byte 0x100 -> words 0x40..0x43, valid 3 cycles after accept.
        pops = 0;
        send_cmd(32'h0000_0100, 16'd4);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            exp_v = (k >= 2) && (k <= 5);
            check($sformatf("t1_valid_k%0d", k), out_valid, exp_v);
            check($sformatf("t1_last_k%0d", k), out_last, (k == 5));
            check($sformatf("t1_done_k%0d", k), done, (k == 6));
        end
        check("t1_pops", pops, 4);

        // Stalled consumer: fifo limits reads in flight, all 8 words delivered in order.
        out_ready = 1'b0;
        pops = 0;
        send_cmd(32'h0000_0200, 16'd8);
        repeat (9) @(negedge clock);
        check("t2_addr_stalled", mem_addr_out, 16'h0084);
        check("t2_valid_stalled", out_valid, 1);
        check("t2_pops_stalled", pops, 0);
        out_ready = 1'b1;
        wait_done(60, "t2_done");
        check("t2_pops", pops, 8);
        check("t2_sb_empty", sb.size(), 0);

        // Zero-length command.
        pops = 0;
        send_cmd(32'h0000_0500, 16'd0);
        check("t3_done_pulse", done, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("t3_done_low", done, 0);
            check("t3_valid_low", out_valid, 0);
            check("t3_cmd_ready", cmd_ready, 1);
        end
        check("t3_pops", pops, 0);

        // Address wrap: words 0xFFFE, 0xFFFF, 0x0000, 0x0001.
        pops = 0;
        send_cmd(32'h0003_FFF8, 16'd4);
        wait_done(40, "t4_done");
        check("t4_pops", pops, 4);
        check("t4_sb_empty", sb.size(), 0);

        // Reset mid-burst discards everything.
        pops = 0;
        send_cmd(32'h0000_0400, 16'd6);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t5_valid_rst", out_valid, 0);
        check("t5_busy_rst", busy, 0);
        check("t5_cmd_ready_rst", cmd_ready, 1);
        check("t5_addr_rst", mem_addr_out, 0);
        check("t5_data_rst", out_data, 0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        pops = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("t5_no_word_after_rst", out_valid, 0);
        end
        send_cmd(32'h0000_0040, 16'd2);
        wait_done(40, "t5_done");
        check("t5_pops", pops, 2);
        check("t5_sb_empty", sb.size(), 0);

        // Toggling out_ready: stability is checked by the monitor.
        out_ready = 1'b0;
        pops = 0;
        send_cmd(32'h0000_0300, 16'd5);
        for (int k = 0; k < 80; k++) begin
            if (done) break;
            check("t6_wb_zero", mem_wb_out, 0);
            out_ready = ~out_ready;
            @(negedge clock);
        end
        check("t6_done", done, 1);
        check("t6_pops", pops, 5);
        check("t6_sb_empty", sb.size(), 0);
        out_ready = 1'b1;
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
